// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: req/ack handshake,
// round-robin or fixed priority with a bounded wait for port 1.
module ram_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter bit RR       = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              grant_vld;
  logic              grant_port;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    grant_vld  = req0 | req1;
    grant_port = req1;
    if (req0 && req1) begin
      if (RR) grant_port = ~owner;
      else    grant_port = (wait_cnt == WCNT_W'(MAX_WAIT));
    end
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = ram_we ? DONE : READ;
      READ:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Requester inputs are sampled only on the grant edge; owner then steers
  // the read-data latch and the ack for the rest of the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      owner     <= 1'b1;
      wait_cnt  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner     <= grant_port;
            ram_addr  <= grant_port ? addr1 : addr0;
            ram_wdata <= grant_port ? wdata1 : wdata0;
            ram_we    <= grant_port ? we1 : we0;
          end
          if (!RR) begin
            if (!req1 || (grant_vld && grant_port))
              wait_cnt <= '0;
            else if (wait_cnt != WCNT_W'(MAX_WAIT))
              wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ISSUE: ram_we <= 1'b0;
        READ: begin
          if (owner) rdata1 <= ram_rdata;
          else       rdata0 <= ram_rdata;
        end
        default: ;
      endcase
      if (state_nxt == DONE) begin
        ack0 <= ~owner;
        ack1 <= owner;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance with a RAM model and
// scoreboards on acks and RAM writes, plus a fixed-priority instance for starvation bounds.
module tb_ram_arbiter;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, ram_we, busy, owner;
  logic [31:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [8:0]  ram_addr;

  logic        b_req0, b_req1;
  logic        b_we0 = 1'b0, b_we1 = 1'b0;
  logic [8:0]  b_addr0 = 9'h010, b_addr1 = 9'h020;
  logic [31:0] b_wdata0 = 32'h0, b_wdata1 = 32'h0;
  logic        b_ack0, b_ack1, b_ram_we, b_busy, b_owner;
  logic [31:0] b_rdata0, b_rdata1, b_ram_wdata, b_ram_rdata;
  logic [8:0]  b_ram_addr;

  logic [31:0] mem [0:511];
  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic        bq[$];
  exp_t        e;
  wr_t         w;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(9), .DATA_W(32), .RR(1'b1), .MAX_WAIT(4)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .busy(busy), .owner(owner)
  );

  ram_arbiter #(.ADDR_W(9), .DATA_W(32), .RR(1'b0), .MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we), .ram_rdata(b_ram_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  assign b_ram_rdata = {23'h0, b_ram_addr};

  // Synchronous RAM: data appears the cycle after the address is sampled.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack and every RAM write strobe must match the next expectation.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (exp_q.size() == 0) check("unexpected_ack", {62'h0, ack1, ack0}, 64'h0);
      else begin
        e = exp_q.pop_front();
        check("ack_port", {62'h0, ack1, ack0}, e.port ? 64'h2 : 64'h1);
        if (!e.we) check("ack_rdata", 64'(e.port ? rdata1 : rdata0), 64'(e.rdata));
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) check("unexpected_we", 64'(ram_we), 64'h0);
      else begin
        w = wr_q.pop_front();
        check("ram_addr", 64'(ram_addr), 64'(w.addr));
        check("ram_wdata", 64'(ram_wdata), 64'(w.data));
      end
    end
  end

  task automatic access(input bit p, input bit wr, input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input bit perturb, input string tag);
    int  k = 0;
    int  we_cyc = 0;
    int  other = 0;
    bit  got = 0;
    exp_q.push_back('{p, wr, rd});
    if (wr) wr_q.push_back('{a, d});
    if (p) begin req1 = 1; we1 = wr; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = wr; addr0 = a; wdata0 = d; end
    while (!got && k < 20) begin
      @(posedge clk); #1;
      if (perturb && k == 0) begin addr0 = ~a; wdata0 = ~d; end
      k++;
      @(negedge clk);
      if (ram_we) we_cyc++;
      if (p ? ack0 : ack1) other++;
      got = p ? ack1 : ack0;
    end
    check({tag, "_latency"}, 64'(k), wr ? 64'd2 : 64'd3);
    check({tag, "_we_cycles"}, 64'(we_cyc), 64'(wr));
    check({tag, "_other_ack"}, 64'(other), 64'h0);
    @(posedge clk); #1;
    if (p) req1 = 0; else req0 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[4];
    int n, cyc, run0, seen;
    reset = 1; req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; b_req0 = 0; b_req1 = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[511] = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {62'h0, ack1, ack0}, 64'h0);
    check("rst_ram_we", 64'(ram_we), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_ram_addr", 64'(ram_addr), 64'h0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'h0);
    check("rst_rdata", {rdata1, rdata0}, 64'h0);
    check("rst_owner", 64'(owner), 64'h1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'h0);

    access(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0, 1'b0, "wr0");
    access(1'b0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0, "rd0");
    access(1'b0, 1'b1, 9'h0A0, 32'h0BADF00D, 32'h0, 1'b1, "capture0");
    access(1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 1'b0, "rd1_511");
    repeat (3) @(negedge clk);
    check("rdata1_held", 64'(rdata1), 64'h12345678);
    check("rdata0_untouched", 64'(rdata0), 64'hDEADBEEF);
    check("owner_last", 64'(owner), 64'h1);

    // Both ports streaming reads under round-robin.
    exp_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    exp_q.push_back('{1'b1, 1'b0, 32'h12345678});
    exp_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    exp_q.push_back('{1'b1, 1'b0, 32'h12345678});
    we0 = 0; we1 = 0; addr0 = 9'h005; addr1 = 9'h1FF; req0 = 1; req1 = 1;
    n = 0; cyc = 0;
    for (int i = 0; i < 4; i++) t[i] = 0;
    while (n < 4 && cyc < 60) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ack0 || ack1) begin t[n] = cyc; n++; end
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    check("rr_ack_count", 64'(n), 64'd4);
    check("rr_p0_period", 64'(t[2] - t[0]), 64'd8);
    check("rr_p1_period", 64'(t[3] - t[1]), 64'd8);
    check("rr_alternate_gap", 64'(t[1] - t[0]), 64'd4);

    // Reset during a write's ISSUE cycle drops ram_we immediately.
    wr_q.push_back('{9'h033, 32'hCAFEF00D});
    req0 = 1; we0 = 1; addr0 = 9'h033; wdata0 = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    check("abort_wr_we_high", 64'(ram_we), 64'h1);
    #2 reset = 1; #1;
    check("abort_wr_we_async", 64'(ram_we), 64'h0);
    check("abort_wr_busy", 64'(busy), 64'h0);
    req0 = 0;
    @(posedge clk); #1 reset = 0;

    // Reset during READ aborts without an ack.
    req1 = 1; we1 = 0; addr1 = 9'h1FF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("abort_rd_busy", 64'(busy), 64'h1);
    #2 reset = 1; #1;
    check("abort_rd_busy_async", 64'(busy), 64'h0);
    check("abort_rd_we", 64'(ram_we), 64'h0);
    check("abort_rd_owner", 64'(owner), 64'h1);
    req1 = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (ack0 || ack1) seen++; end
    @(posedge clk); #1 reset = 0;
    repeat (3) begin @(negedge clk); if (ack0 || ack1) seen++; end
    check("abort_rd_no_ack", 64'(seen), 64'h0);
    check("abort_rd_queue_empty", 64'(exp_q.size() + wr_q.size()), 64'h0);

    // Fixed priority with both ports saturating: 4 port-0 grants then 1 port-1 grant.
    for (int r = 0; r < 2; r++) begin
      repeat (4) bq.push_back(1'b0);
      bq.push_back(1'b1);
    end
    b_req0 = 1; b_req1 = 1;
    cyc = 0; run0 = 0;
    while (bq.size() > 0 && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (b_ack0 || b_ack1) begin
        check("fx_grant_port", 64'(b_ack1), 64'(bq.pop_front()));
        check("fx_ack_onehot", 64'(b_ack0 ^ b_ack1), 64'h1);
        if (b_ack1) begin
          check("fx_wait_cleared", 64'(dut_b.wait_cnt), 64'h0);
          check("fx_rdata1", 64'(b_rdata1), 64'h20);
          run0 = 0;
        end else begin
          run0++;
          if (run0 == 4) check("fx_wait_saturated", 64'(dut_b.wait_cnt), 64'd4);
        end
      end
    end
    check("fx_all_grants", 64'(bq.size()), 64'h0);
    @(posedge clk); #1 b_req0 = 0; b_req1 = 0;
    repeat (3) @(negedge clk);
    check("fx_idle", 64'(b_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between two requesters.
- Port 0 is the CPU datapath's memory interface (MAR/MDR path driven by the control unit); port 1 is a program loader / debug port.
- Serialises accesses with a request/acknowledge handshake, arbitrates fixed-priority or round-robin, and bounds starvation of the lower-priority port.
- Sits between DataPath/Control and the RAM in mini_src_group_1.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data width
RR, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins
MAX_WAIT, 4, fixed mode only: consecutive lost arbitrations before port 1 is forced to win (must be at least 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held high until ack0 is seen
we0  in  1  port 0 write enable, 1 = write, 0 = read
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  one-cycle completion pulse for port 0
rdata0  out  DATA_W  port 0 read data, registered, valid while ack0=1, held until next port-0 read
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
ram_addr  out  ADDR_W  registered RAM address
ram_wdata  out  DATA_W  registered RAM write data
ram_we  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data, valid the cycle after the address is sampled
busy  out  1  high in every state except IDLE
owner  out  1  port currently or last served

Behaviour:
Reset (asynchronous, takes effect immediately):
- state=IDLE.
- ack0, ack1, ram_we, busy = 0.
- ram_addr, ram_wdata, rdata0, rdata1 = 0.
- owner=1, so port 0 wins the first tie; wait counter = 0.
- Reset mid-transaction aborts it: no ack is issued, and ram_we drops asynchronously.

Interface conventions:
- All outputs are registered except busy, which is decoded from state.
- The requester must drop req on the edge that ends its ack cycle.
- A req still high when the FSM is in IDLE is treated as a new request.

FSM states: IDLE -> ISSUE -> (READ) -> DONE -> IDLE
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick winner W, register addrW, wdataW and weW into ram_addr, ram_wdata and ram_we; set owner=W; go to ISSUE.
  - Inputs from W are captured only here; later changes to them are ignored.
- ISSUE:
  - The RAM samples the address/write at the end of this cycle.
  - Next: READ if the captured we=0, else DONE.
  - ram_we clears on leaving ISSUE, so it is high for exactly one cycle.
- READ: ram_rdata is valid; it is latched into rdataW at the end of the cycle; go to DONE.
- DONE: ackW=1 for exactly one cycle; go to IDLE.

Latency, counting edges after req is first sampled in IDLE:
- Write: ack high in cycle 3.
- Read: ack high in cycle 4.
- Minimum spacing between back-to-back grants: write every 3 cycles, read every 4 cycles.

Arbitration, applied only in IDLE:
- Single requester always wins.
- Both requesting, RR=1: the port other than owner wins (strict alternation).
- Both requesting, RR=0: port 0 wins, unless wait_cnt==MAX_WAIT, in which case port 1 wins.
- wait_cnt (fixed mode only):
  - Increments each arbitration port 1 loses while req1=1.
  - Clears when port 1 wins or req1=0 in IDLE.
  - Saturates at MAX_WAIT.
- The unselected port simply keeps waiting; its req is not consumed.

Boundaries:
- Address wrap: none. ADDR_W bits pass through unmodified; address 511 is a valid access.
- A read never disturbs the other port's rdata register.

Test Plan:
1. Reset at t=0, then release → all outputs 0, busy=0; reset asserted while in READ → immediately IDLE, no ack, ram_we=0.
2. Port 0 alone writes addr 0x005, data 0xDEADBEEF → ram_we high for one cycle with that address and data; ack0 in the 3rd cycle; ack1 never asserts.
3. Port 1 reads addr 0x1FF with the RAM model returning 0x12345678 → ack1 in the 4th cycle, rdata1=0x12345678 and held afterwards; rdata0 unchanged.
4. RR=1, both ports issue continuous reads → grant order 0,1,0,1; each port gets an ack every 8 cycles.
5. RR=0, MAX_WAIT=4, both ports request continuously → four port-0 grants, then one port-1 grant, repeating; wait_cnt returns to 0 after each port-1 grant.
6. Port 0 changes addr0/wdata0 during ISSUE → the RAM still sees the values captured in IDLE.
